// File: rtl/fft_sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage: D-entry feedback buffer, butterfly with
// scale/saturate, or frame bypass. Define FFT_SDF_ROUND_EN for round-half-up scaling.

module fft_sdf_sat #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W:0]   val_i,
    input  logic        [1:0]        shift_i,
    output logic signed [DATA_W-1:0] res_o
);
    localparam logic signed [DATA_W+1:0] MAX_V = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] MIN_V = {3'b111, {(DATA_W-1){1'b0}}};
`ifdef FFT_SDF_ROUND_EN
    localparam logic signed [DATA_W+1:0] HALF1 = 1;
    localparam logic signed [DATA_W+1:0] HALF2 = 2;
`endif

    logic signed [DATA_W+1:0] ext, rnd, shf;

    // Two guard bits keep the rounding add from wrapping before saturation.
    always_comb begin
        ext = {val_i[DATA_W], val_i};
        rnd = ext;
`ifdef FFT_SDF_ROUND_EN
        if (shift_i == 2'd1)
            rnd = ext + HALF1;
        else if (shift_i != 2'd0)
            rnd = ext + HALF2;
`endif
        shf = rnd >>> shift_i;
        if (shf > MAX_V)
            res_o = MAX_V[DATA_W-1:0];
        else if (shf < MIN_V)
            res_o = MIN_V[DATA_W-1:0];
        else
            res_o = shf[DATA_W-1:0];
    end
endmodule

module fft_sdf_stage #(
    parameter int DATA_W    = 16,
    parameter int LOG_DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data_r,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data_r,
    output logic signed [DATA_W-1:0] out_data_i,
    input  logic                     next_ready,
    input  logic                     select,
    input  logic        [1:0]        scaling
);
    localparam int D = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, FILL, BFLY, DRAIN, PASS} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    state_t               state_q;
    logic [LOG_DEPTH-1:0] cnt_q;
    logic                 half_q;
    logic                 sel_q;
    logic [1:0]           shift_q;
    logic                 out_valid_q;
    cplx_t                out_q;
    cplx_t                mem_q [D];

    cplx_t                   x, a, mem_wd;
    logic                    out_free, accept, mem_we;
    logic [1:0]              scl_eff;
    logic [3:0][DATA_W:0]    pre;
    logic [3:0][DATA_W-1:0]  post;

    assign x        = {in_data_r, in_data_i};
    assign a        = mem_q[cnt_q];
    assign out_free = !out_valid_q || next_ready;
    assign in_ready = out_free && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign scl_eff  = (scaling == 2'd3) ? 2'd2 : scaling;

    // Lanes: 0/1 = sum re/im, 2/3 = difference re/im.
    assign pre[0] = {a.re[DATA_W-1], a.re} + {x.re[DATA_W-1], x.re};
    assign pre[1] = {a.im[DATA_W-1], a.im} + {x.im[DATA_W-1], x.im};
    assign pre[2] = {a.re[DATA_W-1], a.re} - {x.re[DATA_W-1], x.re};
    assign pre[3] = {a.im[DATA_W-1], a.im} - {x.im[DATA_W-1], x.im};

    for (genvar g = 0; g < 4; g++) begin : g_sat
        fft_sdf_sat #(.DATA_W(DATA_W)) u_sat (
            .val_i   (pre[g]),
            .shift_i (shift_q),
            .res_o   (post[g])
        );
    end

    always_comb begin
        mem_we = accept && ((state_q == IDLE && select) || state_q == FILL || state_q == BFLY);
        mem_wd = (state_q == BFLY) ? {post[2], post[3]} : x;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[cnt_q] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            sel_q       <= 1'b1;
            shift_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (next_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    sel_q   <= select;
                    shift_q <= scl_eff;
                    cnt_q   <= cnt_q + 1'b1;
                    half_q  <= 1'b0;
                    if (select) begin
                        state_q <= FILL;
                    end else begin
                        state_q     <= PASS;
                        out_q       <= x;
                        out_valid_q <= 1'b1;
                    end
                end
                FILL: if (accept) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_q <= BFLY;
                end
                BFLY: if (accept) begin
                    out_q       <= {post[0], post[1]};
                    out_valid_q <= 1'b1;
                    cnt_q       <= cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_q <= DRAIN;
                end
                DRAIN: if (out_free) begin
                    out_q       <= a;
                    out_valid_q <= 1'b1;
                    cnt_q       <= cnt_q + 1'b1;
                    if (cnt_q == LAST)
                        state_q <= IDLE;
                end
                PASS: if (accept) begin
                    out_q       <= x;
                    out_valid_q <= 1'b1;
                    cnt_q       <= cnt_q + 1'b1;
                    // The counter spans half a frame; half_q marks the second lap.
                    if (cnt_q == LAST) begin
                        half_q <= 1'b1;
                        if (half_q)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data_r = out_q.re;
    assign out_data_i = out_q.im;

    logic unused_sel;
    assign unused_sel = sel_q;
endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage (DATA_W=16, LOG_DEPTH=2): scoreboard of expected outputs
// checked with immediate assertions as the DUT hands samples downstream.

module tb_fft_sdf_stage;
    localparam int DW = 16;
    localparam int LD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_data_r = '0;
    logic signed [DW-1:0] in_data_i = '0;
    logic in_ready, out_valid;
    logic signed [DW-1:0] out_data_r, out_data_i;
    logic next_ready = 1'b1;
    logic select = 1'b1;
    logic [1:0] scaling = 2'd0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit tog_en = 1'b0;

    typedef struct {int re; int im;} smp_t;
    smp_t sbq[$];
    smp_t e_m;
    bit stalled = 1'b0;
    logic signed [DW-1:0] hold_r, hold_i;

    always #5 clk = ~clk;

    fft_sdf_stage #(.DATA_W(DW), .LOG_DEPTH(LD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data_r  (in_data_r),
        .in_data_i  (in_data_i),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data_r (out_data_r),
        .out_data_i (out_data_i),
        .next_ready (next_ready),
        .select     (select),
        .scaling    (scaling)
    );

    function automatic int mdl(int s, int sh);
        int v;
        v = s;
`ifdef FFT_SDF_ROUND_EN
        if (sh > 0) v = v + (1 << (sh - 1));
`endif
        v = v >>> sh;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic push_exp(input int er[8], input int ei[8]);
        for (int k = 0; k < 8; k++) sbq.push_back('{re: er[k], im: ei[k]});
    endtask

    task automatic send_sample(input int re, input int im);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data_r = re[DW-1:0];
        in_data_i = im[DW-1:0];
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL accept_timeout obs=%0b exp=1", got);
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic sel, input logic [1:0] scl, input int re[8],
                             input int im[8], input int chg_at, input bit lat);
        select = sel;
        scaling = scl;
        for (int k = 0; k < 8; k++) begin
            send_sample(re[k], im[k]);
            if (lat) begin
                checks++;
                assert (out_valid === 1'b1 && out_data_r === re[k] && out_data_i === im[k]) else begin
                    errors++;
                    $error("FAIL pass_latency k=%0d obs=%0b/%0d exp=1/%0d", k, out_valid, out_data_r, re[k]);
                end
            end
            if (k == chg_at) begin
                select = !sel;
                scaling = 2'd2;
            end
        end
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 200; t++) begin
            if (sbq.size() == 0 && !out_valid) break;
            @(posedge clk);
            #2;
        end
        checks++;
        assert (sbq.size() == 0 && !out_valid) else begin
            errors++;
            $error("FAIL drain_timeout obs=%0d left exp=0", sbq.size());
        end
    endtask

    initial begin
        int r[8], z[8], r2[8], rr[8], ri[8];
        int e028[8], e029a[8], e029b[8], e030a[8], e030b[8], s30b[8], er[8], ei[8];

        r     = '{1, 2, 3, 4, 5, 6, 7, 8};
        z     = '{default: 0};
        e028  = '{6, 8, 10, 12, -4, -4, -4, -4};
        e029a = '{3, 4, 5, 6, -2, -2, -2, -2};
        r2    = '{1, 1, 1, 1, 2, 2, 2, 2};
`ifdef FFT_SDF_ROUND_EN
        e029b = '{2, 2, 2, 2, 0, 0, 0, 0};
`else
        e029b = '{1, 1, 1, 1, -1, -1, -1, -1};
`endif
        e030a = '{32767, 32767, 32767, 32767, 0, 0, 0, 0};
        s30b  = '{-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767};
        e030b = '{-1, -1, -1, -1, -32768, -32768, -32768, -32768};

        fork
            forever begin
                @(posedge clk);
                #1;
                next_ready = tog_en ? !next_ready : 1'b1;
            end
            forever begin
                @(negedge clk);
                if (!mon_en) begin
                    stalled = 1'b0;
                end else begin
                    if (stalled) begin
                        checks++;
                        assert (out_valid === 1'b1 && out_data_r === hold_r && out_data_i === hold_i) else begin
                            errors++;
                            $error("FAIL stall_hold obs=%0b/%0d/%0d exp=1/%0d/%0d",
                                   out_valid, out_data_r, out_data_i, hold_r, hold_i);
                        end
                    end
                    stalled = out_valid && !next_ready;
                    hold_r = out_data_r;
                    hold_i = out_data_i;
                    if (out_valid && next_ready) begin
                        checks++;
                        assert (sbq.size() > 0) else begin
                            errors++;
                            $error("FAIL unexpected_out obs=%0d exp=none", out_data_r);
                        end
                        if (sbq.size() > 0) begin
                            e_m = sbq.pop_front();
                            checks++;
                            assert (out_data_r === e_m.re && out_data_i === e_m.im) else begin
                                errors++;
                                $error("FAIL sb_out obs=%0d/%0d exp=%0d/%0d", out_data_r, out_data_i, e_m.re, e_m.im);
                            end
                        end
                    end
                end
            end
            begin
                #400000;
                $display("FAIL watchdog obs=running exp=finished");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && out_data_r === 0 && out_data_i === 0) else begin
            errors++;
            $error("FAIL reset_out obs=%0b/%0d/%0d exp=0/0/0", out_valid, out_data_r, out_data_i);
        end
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL reset_ready obs=%0b exp=1", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Basic butterfly and DRAIN back-pressure on the input
        push_exp(e028, z);
        run_frame(1'b1, 2'd0, r, z, -1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            assert (in_ready === 1'b0) else begin
                errors++;
                $error("FAIL drain_ready c=%0d obs=%0b exp=0", i, in_ready);
            end
        end
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin
            errors++;
            $error("FAIL idle_ready obs=%0b exp=1", in_ready);
        end
        wait_empty();

        // Scaling by one, rounding sensitivity
        push_exp(e029a, z);
        run_frame(1'b1, 2'd1, r, z, -1, 1'b0);
        wait_empty();
        push_exp(e029b, z);
        run_frame(1'b1, 2'd1, r2, z, -1, 1'b0);
        wait_empty();

        // Saturation
        er = '{default: 32767};
        push_exp(e030a, z);
        run_frame(1'b1, 2'd0, er, z, -1, 1'b0);
        wait_empty();
        push_exp(e030b, z);
        run_frame(1'b1, 2'd0, s30b, z, -1, 1'b0);
        wait_empty();

        // Downstream stalls every other cycle
        tog_en = 1'b1;
        push_exp(e028, z);
        run_frame(1'b1, 2'd0, r, z, -1, 1'b0);
        wait_empty();
        tog_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Bypass with mid-frame control changes, then butterfly with a mid-frame scaling change
        push_exp(r, z);
        run_frame(1'b0, 2'd0, r, z, 2, 1'b1);
        wait_empty();
        push_exp(e028, z);
        run_frame(1'b1, 2'd0, r, z, 2, 1'b0);
        wait_empty();

        // Random complex frame, code 3 behaves as shift 2
        for (int k = 0; k < 8; k++) begin
            rr[k] = int'($urandom_range(0, 65535)) - 32768;
            ri[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        for (int k = 0; k < 4; k++) begin
            er[k]     = mdl(rr[k] + rr[k+4], 2);
            ei[k]     = mdl(ri[k] + ri[k+4], 2);
            er[k + 4] = mdl(rr[k] - rr[k+4], 2);
            ei[k + 4] = mdl(ri[k] - ri[k+4], 2);
        end
        push_exp(er, ei);
        run_frame(1'b1, 2'd3, rr, ri, -1, 1'b0);
        wait_empty();

        // Reset mid-frame
        mon_en = 1'b0;
        select = 1'b1;
        scaling = 2'd0;
        for (int k = 0; k < 5; k++) send_sample(r[k], 0);
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && out_data_r === 0) else begin
            errors++;
            $error("FAIL midframe_reset obs=%0b/%0d exp=0/0", out_valid, out_data_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 mon_en = 1'b1;
        push_exp(e028, z);
        run_frame(1'b1, 2'd0, r, z, -1, 1'b0);
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_sdf_stage.md
FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed width of each real/imag component.
REQ-002 SHALL have parameter LOG_DEPTH, default 5, giving delay depth D=2^LOG_DEPTH and frame length N=2*D (default 64).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input sample valid.
REQ-006 SHALL have ports in_data_r, in_data_i  input  DATA_W  signed input sample.
REQ-007 SHALL have port in_ready  output  1  stage accepts a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  output register holds a valid sample.
REQ-009 SHALL have ports out_data_r, out_data_i  output  DATA_W  signed output sample.
REQ-010 SHALL have port next_ready  input  1  downstream accepts the output this cycle.
REQ-011 SHALL have port select  input  1  1=butterfly, 0=bypass; latched at frame start.
REQ-012 SHALL have port scaling  input  2  shift 0/1/2, code 3 treated as 2; latched at frame start.

Function
REQ-013 SHALL implement states IDLE, FILL, BFLY, DRAIN, PASS, with a LOG_DEPTH-bit sample counter cnt.
REQ-014 SHALL define out_free = !out_valid || next_ready; an input accept = in_valid && in_ready.
REQ-015 SHALL drive in_ready = out_free in IDLE, FILL, BFLY, PASS, and in_ready = 0 in DRAIN.
REQ-016 SHALL, on an accept in IDLE, latch select and scaling, then enter FILL if select=1 (writing the sample), or PASS if select=0 (emitting it).
REQ-017 SHALL, in FILL, write each accepted sample into a D-entry buffer at address cnt, emit nothing, and enter BFLY after D samples.
REQ-018 SHALL, in BFLY, for accepted sample x with buffered a=buf[cnt]: output S(a+x) in the next cycle, and write S(a-x) to buf[cnt]; enter DRAIN after D samples.
REQ-019 SHALL, in DRAIN, on each out_free cycle emit buf[cnt] and increment cnt; enter IDLE after D outputs.
REQ-020 SHALL, in PASS, register each accepted sample unmodified to the output and enter IDLE after N samples.
REQ-021 SHALL compute sum/difference at DATA_W+1 bits, arithmetic-shift right by the latched shift, then saturate to DATA_W (real and imaginary independently).
REQ-022 SHALL have a latency of 1 cycle from BFLY/PASS accept to out_valid; output order is N/2 sums, then N/2 differences.
REQ-023 SHALL clear out_valid when next_ready is high and no new output is loaded, and hold out_data stable while out_valid && !next_ready.
REQ-024 SHALL wrap cnt modulo D at each state change, and ignore select/scaling changes mid-frame.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, cnt=0, out_valid=0, out_data_r=out_data_i=0, latched select=1, latched shift=0.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; buffer contents need not be cleared.

Configuration
REQ-027 SHALL honour the macro FFT_SDF_ROUND_EN: when defined, add 2^(shift-1) before a nonzero shift (round half up); when undefined, truncate toward minus infinity; shift 0 is identical in both.

Verification (DATA_W=16, LOG_DEPTH=2, N=8)
REQ-028 SHALL check: select=1, scaling=0, real inputs 1..8, next_ready=1 -> outputs 6,8,10,12,-4,-4,-4,-4, imag all 0, in_ready low for 4 cycles after input 8.
REQ-029 SHALL check: same inputs, scaling=1, rounding off -> 3,4,5,6,-2,-2,-2,-2; inputs 1,1,1,1,2,2,2,2 -> sums 1 (trunc) versus 2 (FFT_SDF_ROUND_EN), diffs -1 versus 0.
REQ-030 SHALL check: inputs 32767 x4 then 32767 x4 at scaling=0 -> sums saturate to 32767; -32768 x4 then 32767 x4 -> sums -1, diffs saturate to -32768.
REQ-031 SHALL check: next_ready toggled 1/0 each cycle -> identical value sequence to REQ-028, no drop or duplicate, out_data stable while stalled.
REQ-032 SHALL check: select=0, inputs 1..8 -> outputs 1..8, one-cycle latency; changing select/scaling mid-frame -> no effect until the next frame.
REQ-033 SHALL check: rst_n pulsed low after 5 inputs -> out_valid=0 immediately; the next frame 1..8 -> REQ-028 sequence.
